// File: rtl/osd_cmd_tx.sv
// OSD command-port transmitter: turns request handshakes into io_osd/io_strobe/io_din word frames.
// Define OSD_TX_INFO_EN to build the info-window parameter block sent with enable commands.
module osd_cmd_tx #(
  parameter int STROBE_HI = 2,
  parameter int STROBE_LO = 2,
  parameter int GAP       = 4
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic        req_info,
  input  logic [4:0]  req_row,
  input  logic [7:0]  req_len,
  input  logic [11:0] req_infox,
  input  logic [11:0] req_infoy,
  input  logic [5:0]  req_infow,
  input  logic [5:0]  req_infoh,
  input  logic [1:0]  req_rot,
  output logic [7:0]  rd_addr,
  input  logic [7:0]  rd_data,
  output logic        io_osd,
  output logic        io_strobe,
  output logic [15:0] io_din,
  output logic        busy
);

  localparam int PMAX_HL = (STROBE_HI > STROBE_LO) ? STROBE_HI : STROBE_LO;
  localparam int PMAX    = (PMAX_HL > GAP) ? PMAX_HL : GAP;
  localparam int PW      = $clog2(PMAX + 1);

  localparam logic [PW-1:0] HI_LAST  = PW'(STROBE_HI - 1);
  localparam logic [PW-1:0] LO_LAST  = PW'(STROBE_LO - 1);
  localparam logic [PW-1:0] GAP_LAST = PW'(GAP - 1);

  localparam logic [2:0] ST_RST   = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_FRAME = 3'd3;
  localparam logic [2:0] ST_TAIL  = 3'd4;
  localparam logic [2:0] ST_GAP   = 3'd5;

  localparam logic [1:0] OP_DIS = 2'd0;
  localparam logic [1:0] OP_EN  = 2'd1;
  localparam logic [1:0] OP_WR  = 2'd2;

  logic [2:0]    r_state;
  logic          r_hi;
  logic [PW-1:0] r_phase;
  logic [8:0]    r_word;
  logic [8:0]    r_last;
  logic [1:0]    r_op;
  logic [15:0]   r_cmd;
  logic          r_osd;
  logic          r_strobe;
  logic [15:0]   r_din;
  logic [7:0]    r_addr;

  logic          w_info;
  logic [15:0]   w_word;

`ifdef OSD_TX_INFO_EN
  logic [11:0] r_infox;
  logic [11:0] r_infoy;
  logic [5:0]  r_infow;
  logic [5:0]  r_infoh;
  logic [1:0]  r_rot;

  assign w_info = req_info;

  always_ff @(posedge clk_sys) begin
    if (r_state == ST_IDLE && req_valid) begin
      r_infox <= req_infox;
      r_infoy <= req_infoy;
      r_infow <= req_infow;
      r_infoh <= req_infoh;
      r_rot   <= req_rot;
    end
  end
`else
  logic w_unused;

  assign w_info   = 1'b0;
  assign w_unused = ^{req_info, req_infox, req_infoy, req_infow, req_infoh, req_rot};
`endif

  // Word 0 is the command; later words are RAM bytes (write) or info parameters (enable).
  always_comb begin
    w_word = r_cmd;
    if (r_word != 9'd0) begin
      if (r_op == OP_WR) begin
        w_word = {8'h00, rd_data};
      end
`ifdef OSD_TX_INFO_EN
      else begin
        case (r_word[2:0])
          3'd1:    w_word = {4'h0, r_infox};
          3'd2:    w_word = {4'h0, r_infoy};
          3'd3:    w_word = {10'h000, r_infow};
          3'd4:    w_word = {10'h000, r_infoh};
          default: w_word = {14'h0000, r_rot};
        endcase
      end
`endif
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_state  <= ST_RST;
      r_hi     <= 1'b0;
      r_phase  <= '0;
      r_word   <= 9'd0;
      r_last   <= 9'd0;
      r_op     <= 2'd0;
      r_cmd    <= 16'h0000;
      r_osd    <= 1'b0;
      r_strobe <= 1'b0;
      r_din    <= 16'h0000;
      r_addr   <= 8'h00;
    end else begin
      case (r_state)
        ST_RST: r_state <= ST_IDLE;
        ST_IDLE: begin
          if (req_valid) begin
            r_state <= ST_LOAD;
            r_op    <= req_op;
            r_addr  <= 8'h00;
            case (req_op)
              OP_DIS: begin
                r_cmd  <= 16'h0040;
                r_last <= 9'd0;
              end
              OP_EN: begin
                r_cmd  <= {13'h0008, w_info, 2'b01};
                r_last <= w_info ? 9'd5 : 9'd0;
              end
              OP_WR: begin
                r_cmd  <= {11'h001, req_row};
                r_last <= {1'b0, req_len} + 9'd1;
              end
              default: begin
                r_cmd  <= 16'h0000;
                r_last <= 9'd0;
              end
            endcase
          end
        end
        ST_LOAD: begin
          r_hi    <= 1'b0;
          r_phase <= '0;
          r_word  <= 9'd0;
          if (r_op == 2'd3) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_FRAME;
            r_osd   <= 1'b1;
          end
        end
        ST_FRAME: begin
          if (!r_hi) begin
            // rd_addr has been stable since the low phase began, so the byte is ready here.
            if (r_phase == '0) begin
              r_din <= w_word;
            end
            if (r_phase == LO_LAST) begin
              r_hi     <= 1'b1;
              r_phase  <= '0;
              r_strobe <= 1'b1;
            end else begin
              r_phase <= r_phase + 1'b1;
            end
          end else if (r_phase == HI_LAST) begin
            r_hi     <= 1'b0;
            r_phase  <= '0;
            r_strobe <= 1'b0;
            if (r_word == r_last) begin
              r_state <= ST_TAIL;
            end else begin
              r_word <= r_word + 9'd1;
              if (r_op == OP_WR) begin
                r_addr <= r_word[7:0];
              end
            end
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        ST_TAIL: begin
          if (r_phase == LO_LAST) begin
            r_phase <= '0;
            r_osd   <= 1'b0;
            r_state <= ST_GAP;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        ST_GAP: begin
          if (r_phase == GAP_LAST) begin
            r_phase <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == ST_IDLE);
  assign busy      = ~req_ready;
  assign io_osd    = r_osd;
  assign io_strobe = r_strobe;
  assign io_din    = r_din;
  assign rd_addr   = r_addr;

endmodule

// File: tb/tb_osd_cmd_tx.sv
// Directed-vector bench for osd_cmd_tx with default timing parameters and an asynchronous-read byte RAM.
// Expectations follow OSD_TX_INFO_EN when it is defined for the build.
module tb_osd_cmd_tx;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic        req_info;
  logic [4:0]  req_row;
  logic [7:0]  req_len;
  logic [11:0] req_infox;
  logic [11:0] req_infoy;
  logic [5:0]  req_infow;
  logic [5:0]  req_infoh;
  logic [1:0]  req_rot;
  logic [7:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        io_osd;
  logic        io_strobe;
  logic [15:0] io_din;
  logic        busy;

  int checks;
  int failures;

  logic [7:0] ram [256];
  assign rd_data = ram[rd_addr];

  osd_cmd_tx dut (
    .clk_sys   (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_info  (req_info),
    .req_row   (req_row),
    .req_len   (req_len),
    .req_infox (req_infox),
    .req_infoy (req_infoy),
    .req_infow (req_infow),
    .req_infoh (req_infoh),
    .req_rot   (req_rot),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .io_osd    (io_osd),
    .io_strobe (io_strobe),
    .io_din    (io_din),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       op;
    logic             info;
    logic [4:0]       row;
    logic [7:0]       len;
    logic [11:0]      x;
    logic [11:0]      y;
    logic [5:0]       w;
    logic [5:0]       h;
    logic [1:0]       rot;
    int               nWords;
    logic [5:0][15:0] words;
  } vec_t;

  vec_t tbl [7];

  logic [15:0] capWords [$];
  logic [7:0]  capAddr [$];
  int          osdHigh;
  logic [7:0]  lastFrameAddr;
  logic        prevStrobe;
  logic [15:0] prevDin;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Strobe-rise capture plus the every-cycle check that io_din holds while io_strobe is high.
  always @(negedge clk) begin
    if (io_strobe === 1'b1 && prevStrobe !== 1'b1) begin
      capWords.push_back(io_din);
      capAddr.push_back(rd_addr);
    end
    if (io_strobe === 1'b1 && prevStrobe === 1'b1) begin
      checkOutput("dinStableWhileStrobe", {16'h0, io_din}, {16'h0, prevDin});
    end
    if (io_osd === 1'b1) begin
      osdHigh++;
      lastFrameAddr = rd_addr;
    end
    prevStrobe = io_strobe;
    prevDin    = io_din;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clearCapture();
    capWords.delete();
    capAddr.delete();
    osdHigh = 0;
  endtask

  task automatic startRequest(input vec_t v);
    clearCapture();
    req_op    = v.op;
    req_info  = v.info;
    req_row   = v.row;
    req_len   = v.len;
    req_infox = v.x;
    req_infoy = v.y;
    req_infow = v.w;
    req_infoh = v.h;
    req_rot   = v.rot;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  // Issues one request and counts ready-low cycles after the handshake edge.
  task automatic applyStimulus(input vec_t v, input int limit, output int lowCycles,
                               output logic osdFirst, output logic osdSecond);
    startRequest(v);
    lowCycles = 0;
    osdFirst  = 1'bx;
    osdSecond = 1'b0;
    while (!req_ready && lowCycles < limit) begin
      if (lowCycles == 0) osdFirst = io_osd;
      if (lowCycles == 1) osdSecond = io_osd;
      lowCycles++;
      tick();
    end
  endtask

  function automatic vec_t mkVec(input logic [1:0] op, input logic info, input logic [4:0] row,
                                 input logic [7:0] len);
    vec_t v;
    v.op = op; v.info = info; v.row = row; v.len = len;
    v.x = 12'h0; v.y = 12'h0; v.w = 6'h0; v.h = 6'h0; v.rot = 2'd0;
    v.nWords = 0;
    v.words = '0;
    return v;
  endfunction

  initial begin
    int   lowCycles;
    logic osdFirst;
    logic osdSecond;
    vec_t v;

    checks     = 0;
    failures   = 0;
    prevStrobe = 1'b0;
    prevDin    = 16'h0;
    osdHigh    = 0;
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_op = 2'd0; req_info = 1'b0; req_row = 5'd0; req_len = 8'd0;
    req_infox = 12'h0; req_infoy = 12'h0; req_infow = 6'h0; req_infoh = 6'h0; req_rot = 2'd0;

    for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'h5A;
    ram[0] = 8'hA1; ram[1] = 8'hB2; ram[2] = 8'hC3; ram[3] = 8'hD4;

    tbl[0] = mkVec(2'd0, 1'b0, 5'd0, 8'd0);
    tbl[0].nWords = 1; tbl[0].words[0] = 16'h0040;
    tbl[1] = mkVec(2'd1, 1'b0, 5'd0, 8'd0);
    tbl[1].nWords = 1; tbl[1].words[0] = 16'h0041;
    tbl[2] = mkVec(2'd2, 1'b0, 5'd9, 8'd3);
    tbl[2].nWords = 5;
    tbl[2].words[0] = 16'h0029; tbl[2].words[1] = 16'h00A1; tbl[2].words[2] = 16'h00B2;
    tbl[2].words[3] = 16'h00C3; tbl[2].words[4] = 16'h00D4;
    tbl[3] = mkVec(2'd1, 1'b1, 5'd0, 8'd0);
    tbl[3].x = 12'h123; tbl[3].y = 12'h045; tbl[3].w = 6'h3F; tbl[3].h = 6'h08; tbl[3].rot = 2'd3;
`ifdef OSD_TX_INFO_EN
    tbl[3].nWords = 6;
    tbl[3].words[0] = 16'h0045; tbl[3].words[1] = 16'h0123; tbl[3].words[2] = 16'h0045;
    tbl[3].words[3] = 16'h003F; tbl[3].words[4] = 16'h0008; tbl[3].words[5] = 16'h0003;
`else
    tbl[3].nWords = 1; tbl[3].words[0] = 16'h0041;
`endif
    tbl[4] = mkVec(2'd2, 1'b0, 5'd0, 8'd0);
    tbl[4].nWords = 2; tbl[4].words[0] = 16'h0020; tbl[4].words[1] = 16'h00A1;
    tbl[5] = mkVec(2'd3, 1'b1, 5'd7, 8'd9);
    tbl[5].nWords = 0;
    tbl[6] = mkVec(2'd2, 1'b0, 5'd31, 8'd1);
    tbl[6].nWords = 3;
    tbl[6].words[0] = 16'h003F; tbl[6].words[1] = 16'h00A1; tbl[6].words[2] = 16'h00B2;

    // Reset state while reset_n is held low, then ready on the first cycle after release.
    tick(); tick(); tick();
    checkOutput("rstOsd",    {31'h0, io_osd},    32'h0);
    checkOutput("rstStrobe", {31'h0, io_strobe}, 32'h0);
    checkOutput("rstDin",    {16'h0, io_din},    32'h0);
    checkOutput("rstAddr",   {24'h0, rd_addr},   32'h0);
    checkOutput("rstReady",  {31'h0, req_ready}, 32'h0);
    checkOutput("rstBusy",   {31'h0, busy},      32'h1);
    reset_n = 1'b1;
    tick();
    checkOutput("readyAfterRst", {31'h0, req_ready}, 32'h1);
    checkOutput("busyAfterRst",  {31'h0, busy},      32'h0);

    for (int t = 0; t < 7; t++) begin
      v = tbl[t];
      applyStimulus(v, 200, lowCycles, osdFirst, osdSecond);
      tick();
      checkOutput($sformatf("v%0d.readyLow", t), lowCycles, (v.nWords == 0) ? 1 : 4 * v.nWords + 7);
      checkOutput($sformatf("v%0d.osdHigh", t), osdHigh, (v.nWords == 0) ? 0 : 4 * v.nWords + 2);
      checkOutput($sformatf("v%0d.osdLowFirst", t), {31'h0, osdFirst}, 32'h0);
      if (v.nWords > 0) checkOutput($sformatf("v%0d.osdRise", t), {31'h0, osdSecond}, 32'h1);
      checkOutput($sformatf("v%0d.nWords", t), capWords.size(), v.nWords);
      for (int k = 0; k < v.nWords && k < capWords.size(); k++) begin
        checkOutput($sformatf("v%0d.word%0d", t, k), {16'h0, capWords[k]}, {16'h0, v.words[k]});
        if (v.op == 2'd2 && k > 0)
          checkOutput($sformatf("v%0d.addr%0d", t, k), {24'h0, capAddr[k]}, k - 1);
      end
    end

    // Longest write: 257 words, addresses must run 0..255 without wrapping.
    v = mkVec(2'd2, 1'b0, 5'd0, 8'd255);
    applyStimulus(v, 3000, lowCycles, osdFirst, osdSecond);
    tick();
    checkOutput("len255.readyLow", lowCycles, 4 * 257 + 7);
    checkOutput("len255.nWords", capWords.size(), 257);
    if (capWords.size() == 257) begin
      checkOutput("len255.cmd", {16'h0, capWords[0]}, 32'h0020);
      for (int k = 1; k < 257; k++) begin
        checkOutput($sformatf("len255.word%0d", k), {16'h0, capWords[k]}, {24'h0, ram[k-1]});
        checkOutput($sformatf("len255.addr%0d", k), {24'h0, capAddr[k]}, k - 1);
      end
      checkOutput("len255.lastWord", {16'h0, capWords[256]}, 32'h00A5);
    end
    checkOutput("len255.lastFrameAddr", {24'h0, lastFrameAddr}, 32'hFF);

    // Reset pulse during the third data word of a row-9 write.
    v = tbl[2];
    startRequest(v);
    for (int n = 0; n < 200 && capWords.size() < 4; n++) tick();
    checkOutput("midRst.wordsBefore", capWords.size(), 4);
    reset_n = 1'b0;
    tick();
    checkOutput("midRst.osd",    {31'h0, io_osd},    32'h0);
    checkOutput("midRst.strobe", {31'h0, io_strobe}, 32'h0);
    checkOutput("midRst.din",    {16'h0, io_din},    32'h0);
    checkOutput("midRst.ready",  {31'h0, req_ready}, 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    checkOutput("midRst.readyAfter", {31'h0, req_ready}, 32'h1);
    checkOutput("midRst.wordsAfter", capWords.size(), 4);

    // req_valid held high with scrambled fields while a row-2 write is in flight.
    v = mkVec(2'd2, 1'b0, 5'd2, 8'd2);
    clearCapture();
    req_op = v.op; req_info = v.info; req_row = v.row; req_len = v.len;
    req_valid = 1'b1;
    tick();
    lowCycles = 0;
    while (!req_ready && lowCycles < 200) begin
      req_op    = 2'($urandom);
      req_info  = 1'($urandom);
      req_row   = 5'($urandom);
      req_len   = 8'($urandom);
      req_infox = 12'($urandom);
      req_infoy = 12'($urandom);
      req_rot   = 2'($urandom);
      lowCycles++;
      tick();
    end
    req_valid = 1'b0;
    tick();
    checkOutput("held.readyLow", lowCycles, 4 * 4 + 7);
    checkOutput("held.nWords", capWords.size(), 4);
    if (capWords.size() == 4) begin
      checkOutput("held.word0", {16'h0, capWords[0]}, 32'h0022);
      checkOutput("held.word1", {16'h0, capWords[1]}, 32'h00A1);
      checkOutput("held.word2", {16'h0, capWords[2]}, 32'h00B2);
      checkOutput("held.word3", {16'h0, capWords[3]}, 32'h00C3);
    end
    tick(); tick();
    checkOutput("held.idleReady", {31'h0, req_ready}, 32'h1);
    checkOutput("held.idleOsd",   {31'h0, io_osd},    32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/osd_cmd_tx.md
# osd_cmd_tx

Host-side transmitter for the OSD command port. It turns single-request handshakes into the `io_osd` / `io_strobe` / `io_din` word sequences the OSD overlay consumes:
- enable or disable, with an optional info-window parameter block;
- buffer-write bursts, with bytes fetched from a local byte RAM.

It sits in the `clk_sys` domain between the control firmware's register bank and the OSD overlay's command inputs.

## Interface
Parameters:
- `STROBE_HI`, default 2: cycles `io_strobe` is held high per word (≥1).
- `STROBE_LO`, default 2: cycles `io_strobe` is held low before each word and after the last word (≥2).
- `GAP`, default 4: cycles `io_osd` stays low after a command before the next may start (≥2).

Ports (name, direction, width, meaning):
- `clk_sys` in 1: the only clock.
- `reset_n` in 1: synchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block idle; a request is accepted on `req_valid & req_ready`.
- `req_op` in 2: 0 = disable, 1 = enable, 2 = write, 3 = reserved (accepted, no bus activity).
- `req_info` in 1: enable with info window.
- `req_row` in 5: write row; the command's `bcnt` base is `row<<8`.
- `req_len` in 8: write byte count minus 1 (0 → 1 byte, 255 → 256 bytes).
- `req_infox`, `req_infoy` in 12: info window position.
- `req_infow`, `req_infoh` in 6: info window size in units of 8 pixels.
- `req_rot` in 2: rotation code.
- `rd_addr` out 8: byte RAM address.
- `rd_data` in 8: RAM data, valid 1 cycle after `rd_addr`.
- `io_osd` out 1: command frame.
- `io_strobe` out 1: word strobe; the consumer samples on its rising edge.
- `io_din` out 16: word.
- `busy` out 1: equals `~req_ready`.

## Operation
- All request fields are captured at acceptance; later changes to the inputs have no effect on the command in flight.
- Command word:
  - disable: 0x0040;
  - enable: 0x0041 | (`info`<<2);
  - write: 0x0020 | `row`. Rows 8–15 set bit 3, which the consumer treats as highres.
  - Upper byte is always 0.
- Words after the command word:
  - disable: none.
  - enable without info: none.
  - enable with info (`OSD_TX_INFO_EN` only), 5 words:
    - {4'b0,`infox`};
    - {4'b0,`infoy`};
    - {10'b0,`infow`};
    - {10'b0,`infoh`};
    - {14'b0,`rot`}.
  - write: `len`+1 words {8'b0, byte}, where byte k = RAM[k].
- The `rd_addr` for byte k is driven at the start of that word's low phase; `rd_data` is registered into `io_din` on the second low cycle.
- op 3: `req_ready` drops for 1 cycle only; `io_osd` stays low.
- States:
  - IDLE: `req_ready`=1; handshake → FRAME.
  - FRAME: `io_osd`=1; per word, LO phase (`STROBE_LO` cycles) then HI phase (`STROBE_HI` cycles); after the last word's HI phase → TAIL.
  - TAIL: `STROBE_LO` cycles with `io_osd`=1, `io_strobe`=0 → GAP.
  - GAP: `GAP` cycles with `io_osd`=0 → IDLE.
- Counters:
  - word counter 9 bits (max 257 words);
  - phase counter wide enough for max(`STROBE_HI`, `STROBE_LO`, `GAP`).

## Timing
- Reset values, held while `reset_n`=0:
  - `io_osd`=0, `io_strobe`=0, `io_din`=0, `rd_addr`=0;
  - `req_ready`=0, `busy`=1.
- `req_ready`=1 on the first cycle after `reset_n` goes high; state is IDLE.
- Reset asserted mid-frame: all outputs return to reset values on the next edge; no partial word completes; the consumer sees `io_osd` fall.
- `io_osd` rises on the edge after the handshake edge.
- `io_din` is stable from the last LO cycle through the entire HI phase of its word.
- `io_din` never changes while `io_strobe`=1.
- Frame length, with N words: `io_osd` high for N·(`STROBE_LO`+`STROBE_HI`)+`STROBE_LO` cycles.
- `req_ready` returns `GAP` cycles after `io_osd` falls.
- Defaults, disable request: `io_osd` high 6 cycles; `req_ready` high again 11 cycles after the handshake edge.
- A new request can never be accepted during FRAME, TAIL or GAP.

## Configuration
- `OSD_TX_INFO_EN` defined:
  - enable with `req_info`=1 sends 0x0045 plus the 5 info words;
  - `req_info`=0 sends 0x0041 alone.
- `OSD_TX_INFO_EN` undefined:
  - `req_info` is ignored (treated as 0);
  - enable is always the single word 0x0041;
  - the info capture registers are not built.

## Test plan
- Disable after reset:
  - `io_osd` high 6 cycles;
  - one strobe rise with `io_din`=0x0040;
  - `req_ready` back after 4 further low cycles.
- Write, row 9, `len`=3, RAM[0..3]=A1,B2,C3,D4:
  - 5 strobes carrying 0x0029, 0x00A1, 0x00B2, 0x00C3, 0x00D4;
  - `rd_addr` sequence 0..3.
- Write with `len`=255:
  - 257 strobes;
  - final data word = RAM[255];
  - `rd_addr` never wraps past 255 within the frame.
- Enable with info (`OSD_TX_INFO_EN`), x=0x123, y=0x045, w=0x3F, h=0x08, rot=3:
  - words 0x0045, 0x0123, 0x0045, 0x003F, 0x0008, 0x0003.
  - Same request without the macro: single word 0x0041.
- `reset_n` pulsed low during the 3rd data word:
  - `io_osd`, `io_strobe`, `io_din` = 0 on the next edge;
  - `req_ready`=1 one cycle after release.
- `req_valid` held high with changing fields during a frame:
  - no second acceptance until `req_ready`;
  - in-flight words unchanged;
  - `io_din` constant whenever `io_strobe`=1 (checked every cycle).
